// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage -- instruction fetch stage
//
// Purpose
//   Keeps the program counter, issues one instruction-memory read at a time,
//   captures the returned word into the instruction register (IR) and presents
//   the decoded IR fields to the downstream decode/ALU-control stage until
//   that stage accepts them.
//
//   A three-state controller sequences the work:
//     IDLE  : no request outstanding, nothing presented (imem_req=0).
//     FETCH : read request outstanding at imem_addr=PC (imem_req=1).
//     HOLD  : instruction presented (instr_valid=1), no request outstanding.
//
// Handshakes
//   Memory side : imem_req is a registered level. While it is high, imem_addr
//                 is held stable and the word on imem_rdata is taken in the
//                 cycle imem_ack=1. imem_ack is ignored whenever imem_req=0.
//   Decode side : instr_valid/instr_ready follow strict valid/ready rules.
//                 Once instr_valid rises, the fields and pc_out stay constant
//                 until a cycle with instr_valid=1 and instr_ready=1 (a
//                 transfer). instr_valid never depends combinationally on
//                 instr_ready.
//
// Priority (highest first): reset, redirect_valid, normal sequencing.
//   A redirect discards a coincident memory ack (the IR keeps its old value)
//   and drops any held instruction; a redirect in the same cycle as a
//   transfer still counts as that transfer because the consumer has taken it.
//   halt never aborts an outstanding read or drops a held instruction; it
//   only stops the controller from starting the next read.
//
// Ports
//   clk             in   1  clock, all state changes on its rising edge
//   reset           in   1  synchronous active-high reset
//   halt            in   1  level request to stop issuing new fetches
//   redirect_valid  in   1  one-cycle pulse loading redirect_pc
//   redirect_pc     in  32  redirect target, bits [1:0] forced to zero
//   imem_req        out  1  memory read request (registered)
//   imem_addr       out 32  memory read address (current PC)
//   imem_rdata      in  32  instruction word, valid with imem_ack
//   imem_ack        in   1  read completes this cycle
//   instr_valid     out  1  presented fields are valid
//   instr_ready     in   1  consumer accepts the presented instruction
//   opcode          out  6  IR[31:26]
//   rs              out  5  IR[25:21]
//   rt              out  5  IR[20:16]
//   rd              out  5  IR[15:11]
//   shamt           out  5  IR[10:6]
//   function_code   out  6  IR[5:0]
//   r_type          out  1  opcode == 6'b000000
//   pc_out          out 32  PC of the presented instruction
//   dbg_state_o     out  2  controller state (0=IDLE, 1=FETCH, 2=HOLD)
// ---------------------------------------------------------------------------
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        halt,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  function_code,
  output logic        r_type,
  output logic [31:0] pc_out,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic [31:0] ir_q;
  logic [31:0] pc_out_q;
  logic        imem_req_q;
  logic        instr_valid_q;
  logic        r_type_q;
  logic [31:0] redirect_target;

  // The two low bits of the redirect target are dropped by design.
  logic        unused_redirect_lsb;
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // PC stays word aligned; the increment wraps naturally modulo 2^32.
  assign redirect_target = {redirect_pc[31:2], 2'b00};
  assign pc_d            = pc_q + 32'd4;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      pc_q          <= {RESET_PC[31:2], 2'b00};
      ir_q          <= 32'h0000_0000;
      pc_out_q      <= 32'h0000_0000;
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
      r_type_q      <= 1'b0;
    end else if (redirect_valid) begin
      // Redirect wins over ack and over a held instruction. The IR and
      // pc_out keep their previous contents; only the valid flag drops.
      state_q       <= IDLE;
      pc_q          <= redirect_target;
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!halt) begin
            state_q    <= FETCH;
            imem_req_q <= 1'b1;
          end
        end

        FETCH: begin
          // imem_req_q is high throughout FETCH, so an ack here is always
          // one that belongs to the outstanding read.
          if (imem_ack) begin
            ir_q          <= imem_rdata;
            r_type_q      <= (imem_rdata[31:26] == 6'b000000);
            pc_out_q      <= pc_q;
            pc_q          <= pc_d;
            state_q       <= HOLD;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b1;
          end
        end

        HOLD: begin
          // instr_valid_q is high throughout HOLD, so ready alone marks a
          // transfer. halt decides whether the next read starts at once.
          if (instr_ready) begin
            instr_valid_q <= 1'b0;
            if (halt) begin
              state_q    <= IDLE;
              imem_req_q <= 1'b0;
            end else begin
              state_q    <= FETCH;
              imem_req_q <= 1'b1;
            end
          end
        end

        default: begin
          state_q       <= IDLE;
          imem_req_q    <= 1'b0;
          instr_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req      = imem_req_q;
  assign imem_addr     = pc_q;
  assign instr_valid   = instr_valid_q;
  assign opcode        = ir_q[31:26];
  assign rs            = ir_q[25:21];
  assign rt            = ir_q[20:16];
  assign rd            = ir_q[15:11];
  assign shamt         = ir_q[10:6];
  assign function_code = ir_q[5:0];
  assign r_type        = r_type_q;
  assign pc_out        = pc_out_q;
  assign dbg_state_o   = state_q;

endmodule
